// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divide handshake: FSM encoding and
// the start/ready level names used on the div_unit ports.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: subtract the divisor from the current partial
// remainder and shift in a quotient bit (1 on success, 0 with restore).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH:0]   work_o
);

    logic [WIDTH:0] diff;

    // Extra top bit of diff is the borrow; partial remainder sits in work_i[2W-1:W].
    always_comb begin
        diff = {1'b0, work_i[2*WIDTH-1:WIDTH]} - {1'b0, divisor_i};
        if (diff[WIDTH]) begin
            work_o = {work_i, 1'b0};
        end else begin
            work_o = {diff[WIDTH-1:0], work_i[WIDTH-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-step restoring divider answering the EX-stage divide handshake.
// Returns {remainder, quotient}; one divide in flight, annul_i aborts it.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               sgn_q, sgn_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [2*WIDTH:0]   work_step;
    logic [WIDTH-1:0]   op1_abs, op2_abs, quo, rem;
    logic               go;

    div_step #(.WIDTH(WIDTH)) u_step (
        .work_i    (work_q[2*WIDTH-1:0]),
        .divisor_i (divisor_q),
        .work_o    (work_step)
    );

    assign go      = (start_i == DIV_START) && !annul_i;
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? '0 - opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? '0 - opdata2_i : opdata2_i;
    // Remainder takes the dividend's sign; quotient negative when signs differ.
    assign quo = (sgn_q && (s1_q ^ s2_q)) ? '0 - work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign rem = (sgn_q && s1_q) ? '0 - work_q[2*WIDTH:WIDTH+1] : work_q[2*WIDTH:WIDTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sgn_q     <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            ready_q   <= DIV_RESULT_NOT_READY;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            sgn_q     <= sgn_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (go) state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: state_d = annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (annul_i || start_i == DIV_STOP) state_d = DIV_FREE;
                else if (cnt_q == CNT_W'(WIDTH))    state_d = DIV_END;
            end
            DIV_END: begin
                if (start_i == DIV_STOP) state_d = DIV_FREE;
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sgn_d     = sgn_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        ready_d   = ready_q;
        result_d  = result_q;
        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (state_d == DIV_ON) begin
                    work_d    = {{WIDTH{1'b0}}, op1_abs, 1'b0};
                    divisor_d = op2_abs;
                    sgn_d     = signed_div_i;
                    s1_d      = opdata1_i[WIDTH-1];
                    s2_d      = opdata2_i[WIDTH-1];
                    cnt_d     = '0;
                end
            end
            DIV_BYZERO: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
            end
            DIV_ON: begin
                if (state_d == DIV_FREE) begin
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (state_d == DIV_END) begin
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem, quo};
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DIV_END: begin
                // A divide-by-zero arrives here with ready low; it rises one edge later.
                if (state_d == DIV_FREE) begin
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    ready_d = DIV_RESULT_READY;
                end
            end
            default: ;
        endcase
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb, sq, sr;
        logic [31:0] q, r;
        if (b == 0) return 64'd0;
        if (s) begin
            sa = a; sb = b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sq = sa / sb; sr = sa % sb;
            q = sq; r = sr;
        end else begin
            q = a / b; r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full handshake: raise start, wait for ready, check latency/result,
    // hold two extra cycles, then drop start for one cycle.
    task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] exp;
        exp = ref_div(s, a, b);
        signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
        n = 1;
        while (!ready_o && n < 40) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(n - 1), (b == 0) ? 64'd2 : 64'd33);
        chk({tag, "_res"}, result_o, exp);
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_drop"}, {ready_o, result_o[62:0]}, 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] a, b;
        logic        s;
        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", {ready_o, result_o[62:0]}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_div("u7_2",   1'b0, 32'd7,          32'd2);
        chk("u7_2_const", ref_div(1'b0, 32'd7, 32'd2), 64'h00000001_00000003);
        do_div("s-7_2",  1'b1, 32'hFFFF_FFF9,  32'd2);
        do_div("s7_-2",  1'b1, 32'd7,          32'hFFFF_FFFE);
        do_div("uFF_1",  1'b0, 32'hFFFF_FFFF,  32'd1);
        do_div("s_ovf",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
        do_div("u_big",  1'b0, 32'hFFFF_FFFF,  32'h8000_0001);
        do_div("byzero", 1'b0, 32'd1234,       32'd0);

        // Annul mid-divide: no result may appear.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_out", {ready_o, result_o[62:0]}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        chk("annul_noready", 64'(seen), 64'd0);
        do_div("u9_3", 1'b0, 32'd9, 32'd3);

        // Reset in the middle of a divide.
        signed_div_i = 1'b1; opdata1_i = 32'd5000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {ready_o, result_o[62:0]}, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        chk("rst_noready", 64'(seen), 64'd0);

        // Back-to-back: do_div ends with a single idle cycle before the next start.
        do_div("b2b_a", 1'b0, 32'd1000, 32'd7);
        do_div("b2b_b", 1'b1, 32'hFFFF_FC18, 32'd9);

        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom_range(1, 15);
                1:       b = $urandom;
                2:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                3:       b = 32'd0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (b == 0 && i % 2 == 0) b = 32'd1;
            do_div($sformatf("rnd%0d", i), s, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
